pwm_bank: RTL

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS PWM outputs driven from one shared WIDTH-bit counter.
// Each period's length and the duties are taken from double-buffered
// registers that update only at the period boundary, so a period is never
// torn by a mid-period write.
// Duty updates arrive through a valid/ready handshake into one pending
// buffer that holds all channels; that buffer transfers to the active
// duties at the next boundary.
// Optional build macro PWM_BANK_CENTER_EN switches the counter from an
// up-only sawtooth to up/down counting, which gives centre-aligned pulses.
module pwm_bank #(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_data,
  input  logic                      duty_valid,
  output logic                      duty_ready,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  // Shared counter and active period.
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic [WIDTH-1:0] period_act_q, period_act_d;

  // Active duties and the pending buffer, one WIDTH-bit slot per channel.
  logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0] pend_q, pend_d;
  logic                           pend_full_q, pend_full_d;

  // Registered outputs.
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q, ps_d;

  logic boundary;
  logic load;
  logic accept;

`ifdef PWM_BANK_CENTER_EN
  // High while the counter walks back down from period_act to 1.
  logic dir_down_q, dir_down_d, dir_next;
`endif

  assign duty_ready = ~pend_full_q;
  assign accept     = duty_valid & duty_ready;

`ifdef PWM_BANK_CENTER_EN
  // Counter step for up/down counting: 0..P, then P-1..1, then back to 0.
  always_comb begin
    cnt_next = cnt_q;
    dir_next = dir_down_q;
    if (!dir_down_q) begin
      if (cnt_q >= period_act_q) begin
        // If P is 0 or 1, the down leg is empty, so the counter returns to 0 directly.
        if (cnt_q <= WIDTH'(1)) begin
          cnt_next = '0;
          dir_next = 1'b0;
        end else begin
          cnt_next = cnt_q - WIDTH'(1);
          dir_next = 1'b1;
        end
      end else begin
        cnt_next = cnt_q + WIDTH'(1);
      end
    end else begin
      if (cnt_q <= WIDTH'(1)) begin
        cnt_next = '0;
        dir_next = 1'b0;
      end else begin
        cnt_next = cnt_q - WIDTH'(1);
      end
    end
  end
`else
  // Counter step for the sawtooth: 0..P, then wrap to 0.
  always_comb begin
    cnt_next = cnt_q + WIDTH'(1);
    // The >= comparison still wraps if the counter is somehow past P.
    if (cnt_q >= period_act_q) begin
      cnt_next = '0;
    end
  end
`endif

  // A boundary is any running cycle whose successor restarts the count at 0.
  // While disabled, the buffers transfer every cycle.
  always_comb begin
    boundary = (cnt_next == '0);
    load     = ~enable | boundary;
  end

  // Next state for the counter, the active registers and the pending buffer.
  always_comb begin
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
`ifdef PWM_BANK_CENTER_EN
    dir_down_d   = dir_down_q;
`endif

    if (enable) begin
      cnt_d = cnt_next;
`ifdef PWM_BANK_CENTER_EN
      dir_down_d = dir_next;
`endif
    end else begin
      cnt_d = '0;
`ifdef PWM_BANK_CENTER_EN
      dir_down_d = 1'b0;
`endif
    end

    if (load) begin
      period_act_d = period;
      if (pend_full_q) begin
        duty_act_d  = pend_q;
        pend_full_d = 1'b0;
      end
    end

    // accept needs an empty buffer, so it never races the transfer above.
    if (accept) begin
      pend_d      = duty_data;
      pend_full_d = 1'b1;
    end
  end

  // Output compare: each output is one cycle behind the counter value it reflects.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable & (cnt_q < duty_act_q[i]);
    end
    ps_d = enable & (cnt_q == '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      pwm_q        <= '0;
      ps_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      pwm_q        <= pwm_d;
      ps_q         <= ps_d;
    end
  end

`ifdef PWM_BANK_CENTER_EN
  // Direction register for up/down counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_down_q <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
    end
  end
`endif

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
